sqacc_frame_ctrl: RTL
=====================

# sqacc_frame_ctrl

Frame sequencer for the 8-bit square-accumulate datapath. It owns the input sample register and the accumulator, and counts accepted samples into frames of FRAME_LEN. The accumulator restarts at the first sample of every frame. Each finished frame's sum of squares is presented with an overflow flag on a valid/ready output port, and upstream is back-pressured whenever a finished sum could not be stored. It sits between the sample source and the result consumer and replaces free-running accumulation with framed, flow-controlled operation.

## Interface
- FRAME_LEN, 4: samples per frame. Legal range is 1 to 255.
- ACC_W, 20: accumulator and result width in bits. Minimum is 16.

- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- a  input  8  unsigned sample
- valid_in  input  1  sample on a is valid
- ready_in  output  1  block accepts a sample this cycle
- f  output  ACC_W  sum of squares of the completed frame
- overflow  output  1  the completed frame exceeded 2^ACC_W-1
- valid_out  output  1  f and overflow hold a result
- ready_out  input  1  consumer takes the result this cycle
- busy  output  1  a partial frame is in progress or a sample is in the pipeline

## Operation
- Accept: a sample is accepted on a posedge with valid_in && ready_in.
  - Gaps in valid_in do not affect frame counting.
- Stage 1: an accepted sample is registered as a_q with flags s1_vld, s1_first and s1_last. s1_last is set when it is sample FRAME_LEN of its frame.
- Stage 2: when s1_vld, the sum is computed as acc_next = (s1_first ? 0 : acc) + a_q*a_q.
  - The product is 16 bits, zero-extended to ACC_W+1 bits for the add.
  - An ovf_acc flag ORs in bit ACC_W of that add. On s1_first it is cleared before the OR.
- Completion: when s1_last, acc_next is written to f and ovf_acc|carry to overflow, and valid_out is set.
- Frame counter: cnt counts 0 to FRAME_LEN-1 on accepted samples and wraps to 0 after the last sample.
- Flow control:
  - ready_in = !(cnt==FRAME_LEN-1 && ((valid_out && !ready_out) || s1_last)).
  - Non-last samples are always accepted, and the next frame accumulates while a result is held.
- Output: f and overflow are stable while valid_out=1 && ready_out=0. valid_out clears on the posedge where valid_out && ready_out.
- busy = (cnt!=0) || s1_vld.
- Reset:
  - f=0, overflow=0, valid_out=0.
  - cnt=0, acc=0, s1_vld=0, so ready_in=1 and busy=0 after reset.
  - A partial frame is discarded.
  - A pending, unconsumed result is discarded.

## Timing
- Latency: last sample accepted at edge k gives f, overflow and valid_out after edge k+1.
- Throughput: 1 sample/clk with no back-pressure, for FRAME_LEN≥2.
  - With FRAME_LEN=1 the s1_last term caps throughput at 1 sample per 2 clks.
- Frame boundary: the first sample of frame n+1 may be accepted at edge k+1, the same edge that writes frame n's result. It still accumulates from 0.
- Simultaneous handshake: if valid_out && ready_out at edge k and a last sample is accepted at edge k, valid_out is 0 after k and 1 after k+1 with the new f.
- Reset asserted during any edge takes priority over accept and handshake.

## Configuration
- SQACC_SAT_EN defined: on overflow, f is forced to 2^ACC_W-1 (all ones) for that frame. Later adds in the frame keep it saturated; overflow=1.
- SQACC_SAT_EN undefined: f is the sum modulo 2^ACC_W (wraps); overflow=1 still reports the wrap.

## Test plan
- Basic frame (FRAME_LEN=4, ACC_W=20, ready_out=1): a=21,36,64,0 on consecutive cycles.
  - Required: valid_out=1 and f=5833, overflow=0, one cycle after the 4th accept.
  - Required: valid_out=0 next cycle.
- Gaps and back-to-back frames: 255,255,255,255, then 1,2,3,4 with valid_in low on alternate cycles.
  - Required: f=260100, then f=30; the second frame starts from 0.
- Back-pressure: ready_out=0 after the first frame (5833), then stream the second frame 1,1,1,1.
  - Required: ready_in=0 once 3 samples are accepted; f holds 5833.
  - Raise ready_out. Required: ready_in=1 the same cycle, the 4th sample is accepted, then f=4.
- Overflow (ACC_W=17, FRAME_LEN=4): 255×4.
  - Required: overflow=1, f=129028 without SQACC_SAT_EN, f=131071 with it.
- Reset mid-frame: accept 2 samples, pulse reset for 1 cycle, then send 3,3,3,3.
  - Required: busy=0 and valid_out=0 after reset, then f=36.
- FRAME_LEN=1: stream 2,3,4 with ready_out=1.
  - Required: results 4, 9, 16, each one cycle after its accept.
  - Required: ready_in low every other cycle.

Source files
------------

// File: rtl/sqacc_frame_ctrl_if.sv
// rtl/sqacc_frame_ctrl_if.sv - sample/result handshake bundle for sqacc_frame_ctrl
interface sqacc_frame_ctrl_if #(
  parameter int ACC_W = 20
);
  logic [7:0]       a;
  logic             valid_in;
  logic             ready_in;
  logic [ACC_W-1:0] f;
  logic             overflow;
  logic             valid_out;
  logic             ready_out;
  logic             busy;

  modport master (
    output a, valid_in, ready_out,
    input  ready_in, f, overflow, valid_out, busy
  );

  modport slave (
    input  a, valid_in, ready_out,
    output ready_in, f, overflow, valid_out, busy
  );
endinterface

// File: rtl/sqacc_frame_ctrl.sv
// rtl/sqacc_frame_ctrl.sv - framed, flow-controlled square-accumulate sequencer
// Optional SQACC_SAT_EN: saturate the frame sum to all ones on overflow.
module sqacc_frame_ctrl #(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 20
) (
  input  logic               clk,
  input  logic               reset,
  sqacc_frame_ctrl_if.slave  bus
);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  logic [7:0]       cnt_q;
  logic [7:0]       a_q;
  logic             s1_vld_q;
  logic             s1_first_q;
  logic             s1_last_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_acc_q;
  logic [ACC_W-1:0] f_q;
  logic             ovf_q;
  logic             vout_q;

  logic [15:0]      sq;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_acc_d;
  logic             ready_in;
  logic             accept;

  // The last sample of a frame is held off while its result slot is occupied.
  assign ready_in = !((cnt_q == LAST) && ((vout_q && !bus.ready_out) || s1_last_q));
  assign accept   = bus.valid_in && ready_in;

  always_comb begin
    sq        = {8'd0, a_q} * {8'd0, a_q};
    base      = s1_first_q ? '0 : acc_q;
    sum       = {1'b0, base} + {{(ACC_W-15){1'b0}}, sq};
    ovf_acc_d = (s1_first_q ? 1'b0 : ovf_acc_q) | sum[ACC_W];
`ifdef SQACC_SAT_EN
    acc_d     = ovf_acc_d ? '1 : sum[ACC_W-1:0];
`else
    acc_d     = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      a_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      f_q        <= '0;
      ovf_q      <= 1'b0;
      vout_q     <= 1'b0;
    end else begin
      s1_vld_q   <= accept;
      s1_first_q <= accept && (cnt_q == 8'd0);
      s1_last_q  <= accept && (cnt_q == LAST);
      if (accept) begin
        a_q   <= bus.a;
        cnt_q <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      if (s1_vld_q) begin
        acc_q     <= acc_d;
        ovf_acc_q <= ovf_acc_d;
      end
      // A completing frame wins over the consumer handshake in the same cycle.
      if (s1_vld_q && s1_last_q) begin
        f_q    <= acc_d;
        ovf_q  <= ovf_acc_d;
        vout_q <= 1'b1;
      end else if (vout_q && bus.ready_out) begin
        vout_q <= 1'b0;
      end
    end
  end

  assign bus.ready_in  = ready_in;
  assign bus.f         = f_q;
  assign bus.overflow  = ovf_q;
  assign bus.valid_out = vout_q;
  assign bus.busy      = (cnt_q != 8'd0) || s1_vld_q;
endmodule
